// File: rtl/hamming_enc_pipe.sv
// hamming_enc_pipe: two-stage (72,64) SEC-DED Hamming encoder with valid/ready flow control and error injection
//   i_clk, i_rst_n                                  clock, asynchronous active-low reset
//   i_en                                            0 zeroes the check bits of words entering stage 2
//   i_pattern, i_valid, o_ready                     input word handshake
//   i_inj_req, i_inj_pos, i_inj_dbl, o_inj_busy     single/double bit error injection
//   o_pattern, o_parity, o_valid, i_ready           encoded output handshake, o_parity = {overall, h[6:0]}
module hamming_enc_pipe #(
    parameter int DATA_W = 64,
    parameter int PAR_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_pattern,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_inj_req,
    input  logic [6:0]        i_inj_pos,
    input  logic              i_inj_dbl,
    output logic              o_inj_busy,
    output logic [DATA_W-1:0] o_pattern,
    output logic [PAR_W-1:0]  o_parity,
    output logic              o_valid,
    input  logic              i_ready
);
    logic              s1_v, s2_v, adv, inj_busy, inj_dbl;
    logic [DATA_W-1:0] s1_d, s2_d;
    logic [PAR_W-2:0]  s1_h;
    logic [PAR_W-1:0]  s2_p, par_full;
    logic [6:0]        inj_pos, pos2;
    logic [PAR_W+DATA_W-1:0] inj_mask;

    // Data bit j sits at the j-th non-power-of-two code position counting up from 3.
    function automatic logic [PAR_W-2:0] calc_h(input logic [DATA_W-1:0] d);
        logic [PAR_W-2:0] h;
        int j;
        h = '0;
        j = 0;
        for (int p = 3; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                for (int k = 0; k < PAR_W - 1; k++) h[k] = h[k] ^ (p[k] & d[j]);
                j++;
            end
        end
        return h;
    endfunction

    // One-hot mask over {parity, data} for a code position; 72 is the overall parity bit.
    function automatic logic [PAR_W+DATA_W-1:0] pos_mask(input logic [6:0] q);
        logic [PAR_W+DATA_W-1:0] m;
        int j, k;
        m = '0;
        j = 0;
        k = 0;
        for (int p = 1; p < 72; p++) begin
            if ((p & (p - 1)) == 0) begin
                if (int'(q) == p) m[DATA_W + k] = 1'b1;
                k++;
            end else begin
                if (int'(q) == p) m[j] = 1'b1;
                j++;
            end
        end
        if (q == 7'd72) m[DATA_W + PAR_W - 1] = 1'b1;
        return m;
    endfunction

    assign adv        = s1_v && (!s2_v || i_ready);
    assign o_ready    = !s1_v || !s2_v || i_ready;
    assign o_valid    = s2_v;
    assign o_pattern  = s2_d;
    assign o_parity   = s2_p;
    assign o_inj_busy = inj_busy;

    // Out-of-range positions yield an empty mask, so the armed request is simply discarded on application.
    always_comb begin
        pos2     = (inj_pos == 7'd72) ? 7'd1 : inj_pos + 7'd1;
        inj_mask = (inj_busy && inj_pos != 7'd0 && inj_pos <= 7'd72) ?
                   (pos_mask(inj_pos) | (inj_dbl ? pos_mask(pos2) : '0)) : '0;
        par_full = i_en ? {^{s1_d, s1_h}, s1_h} : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_v     <= 1'b0;
            s1_d     <= '0;
            s1_h     <= '0;
            s2_v     <= 1'b0;
            s2_d     <= '0;
            s2_p     <= '0;
            inj_busy <= 1'b0;
            inj_pos  <= '0;
            inj_dbl  <= 1'b0;
        end else begin
            if (o_ready) begin
                s1_v <= i_valid;
                if (i_valid) begin
                    s1_d <= i_pattern;
                    s1_h <= calc_h(i_pattern);
                end
            end
            if (adv) begin
                s2_v <= 1'b1;
                s2_d <= s1_d ^ inj_mask[DATA_W-1:0];
                s2_p <= par_full ^ inj_mask[DATA_W +: PAR_W];
            end else if (i_ready) begin
                s2_v <= 1'b0;
            end
            // A request arriving while busy is dropped, including on the apply edge itself.
            if (inj_busy) begin
                inj_busy <= !adv;
            end else if (i_inj_req) begin
                inj_busy <= 1'b1;
                inj_pos  <= i_inj_pos;
                inj_dbl  <= i_inj_dbl;
            end
        end
    end
endmodule

// File: tb/tb_hamming_enc_pipe.sv
// tb_hamming_enc_pipe: self-checking bench for hamming_enc_pipe against a code-position reference model
module tb_hamming_enc_pipe;
    logic        i_clk = 1'b0;
    logic        i_rst_n, i_en, i_valid, i_inj_req, i_inj_dbl, i_ready;
    logic [63:0] i_pattern;
    logic [6:0]  i_inj_pos;
    logic        o_ready, o_inj_busy, o_valid;
    logic [63:0] o_pattern;
    logic [7:0]  o_parity;
    int checks = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    hamming_enc_pipe dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
        .i_pattern(i_pattern), .i_valid(i_valid), .o_ready(o_ready),
        .i_inj_req(i_inj_req), .i_inj_pos(i_inj_pos), .i_inj_dbl(i_inj_dbl), .o_inj_busy(o_inj_busy),
        .o_pattern(o_pattern), .o_parity(o_parity), .o_valid(o_valid), .i_ready(i_ready)
    );

    // Builds the full 72-position codeword, optionally corrupts it, and reads back {parity, data}.
    function automatic logic [71:0] ref_enc(input logic [63:0] d, input bit en, input bit inj, input int pos, input bit dbl);
        bit c [1:72];
        bit x;
        logic [63:0] od;
        logic [7:0] op;
        int j;
        for (int p = 1; p <= 72; p++) c[p] = 0;
        j = 0;
        for (int p = 1; p <= 71; p++) if ((p & (p - 1)) != 0) begin c[p] = d[j]; j++; end
        for (int k = 0; k < 7; k++) begin
            x = 0;
            for (int p = 1; p <= 71; p++) if (p[k]) x ^= c[p];
            c[1 << k] = x;
        end
        x = 0;
        for (int p = 1; p <= 71; p++) x ^= c[p];
        c[72] = x;
        if (!en) begin
            for (int k = 0; k < 7; k++) c[1 << k] = 0;
            c[72] = 0;
        end
        if (inj && pos >= 1 && pos <= 72) begin
            c[pos] ^= 1;
            if (dbl) c[pos == 72 ? 1 : pos + 1] ^= 1;
        end
        j = 0;
        for (int p = 1; p <= 71; p++) if ((p & (p - 1)) != 0) begin od[j] = c[p]; j++; end
        for (int k = 0; k < 7; k++) op[k] = c[1 << k];
        op[7] = c[72];
        return {op, od};
    endfunction

    task automatic chk(input string tag, input logic [72:0] got, input logic [72:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic arm(input int pos, input bit dbl);
        i_inj_req = 1'b1;
        i_inj_pos = 7'(pos);
        i_inj_dbl = dbl;
        tick();
        i_inj_req = 1'b0;
    endtask

    // Sends one word into an empty pipeline, checks 2-cycle latency and the result, then consumes it.
    task automatic send_one(input logic [63:0] d, input logic [71:0] exp, input string tag);
        int n;
        i_pattern = d;
        i_valid = 1'b1;
        i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        n = 1;
        while (!o_valid && n < 10) begin tick(); n++; end
        chk({tag, "_lat"}, 73'(n), 73'd2);
        chk(tag, {o_parity, o_pattern}, exp);
        tick();
    endtask

    // mode 0: valid=ready=1; mode 1: valid=1, ready 1,0,0,1...; mode 2: both random
    task automatic run_stream(input int n, input int mode, input string tag);
        logic [71:0] q [$];
        logic [71:0] hold, exp;
        bit held;
        bit rp [4];
        int sent, got, cyc;
        rp = '{1'b1, 1'b0, 1'b0, 1'b1};
        sent = 0;
        got = 0;
        cyc = 0;
        i_en = 1'b1;
        while (got < n && cyc < 40 * n) begin
            i_ready = mode == 0 ? 1'b1 : mode == 1 ? rp[cyc % 4] : ($urandom_range(0, 1) == 1);
            i_valid = (sent < n) && (mode != 2 || $urandom_range(0, 3) != 0);
            i_pattern = {$urandom, $urandom};
            @(negedge i_clk);
            held = o_valid && !i_ready;
            hold = {o_parity, o_pattern};
            if (o_valid && i_ready) begin
                exp = 'x;
                if (q.size() > 0) exp = q.pop_front();
                chk(tag, {o_parity, o_pattern}, exp);
                got++;
            end
            if (i_valid && o_ready) begin
                q.push_back(ref_enc(i_pattern, 1, 0, 0, 0));
                sent++;
            end
            tick();
            if (held) chk({tag, "_hold"}, {o_valid, o_parity, o_pattern}, {1'b1, hold});
            cyc++;
        end
        chk({tag, "_count"}, 73'(got), 73'(n));
        if (mode == 0) chk({tag, "_cycles"}, 73'(cyc), 73'(n + 2));
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (3) tick();
        chk({tag, "_drained"}, {o_valid, 72'(q.size())}, 73'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] d, a;
        int pos;
        bit dbl, en;
        i_rst_n = 1'b0;
        i_en = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_pattern = '0;
        i_inj_req = 1'b0;
        i_inj_pos = '0;
        i_inj_dbl = 1'b0;
        repeat (2) tick();
        chk("rst_valid", 73'(o_valid), 73'd0);
        chk("rst_busy", 73'(o_inj_busy), 73'd0);
        chk("rst_out", {o_parity, o_pattern}, 73'd0);
        chk("rst_ready", 73'(o_ready), 73'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        send_one(64'h0, {8'h00, 64'h0}, "zero");
        send_one(64'h1, {8'h83, 64'h1}, "one");
        send_one(64'h2, {8'h85, 64'h2}, "two");

        i_valid = 1'b1;
        i_pattern = 64'h1;
        tick();
        i_pattern = 64'h2;
        tick();
        i_valid = 1'b0;
        chk("b2b_first", {o_valid, o_parity, o_pattern}, {1'b1, 8'h83, 64'h1});
        tick();
        chk("b2b_second", {o_valid, o_parity, o_pattern}, {1'b1, 8'h85, 64'h2});
        tick();
        chk("b2b_empty", 73'(o_valid), 73'd0);

        run_stream(8, 1, "stall");
        run_stream(20, 0, "full");
        run_stream(30, 2, "rand");

        arm(3, 0);
        chk("inj3_armed", 73'(o_inj_busy), 73'd1);
        i_pattern = 64'h0;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        chk("inj3_busy_s1", 73'(o_inj_busy), 73'd1);
        tick();
        chk("inj3_busy_apply", 73'(o_inj_busy), 73'd0);
        chk("inj3_out", {o_valid, o_parity, o_pattern}, {1'b1, 8'h00, 64'h1});
        tick();

        arm(72, 1);
        arm(3, 0);
        chk("inj72_busy", 73'(o_inj_busy), 73'd1);
        send_one(64'h0, {8'h81, 64'h0}, "inj72");
        chk("inj72_clear", 73'(o_inj_busy), 73'd0);
        send_one(64'h0, {8'h00, 64'h0}, "inj_ignored");

        arm(0, 1);
        send_one(64'h1, {8'h83, 64'h1}, "inj_pos0");
        chk("inj_pos0_clear", 73'(o_inj_busy), 73'd0);
        arm(100, 0);
        send_one(64'h2, {8'h85, 64'h2}, "inj_pos100");
        chk("inj_pos100_clear", 73'(o_inj_busy), 73'd0);

        i_en = 1'b0;
        send_one(64'h1, {8'h00, 64'h1}, "en0");
        arm(1, 0);
        send_one(64'h1, {8'h01, 64'h1}, "en0_inj");
        i_en = 1'b1;

        a = 64'h5;
        i_pattern = a;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_inj_req = 1'b1;
        i_inj_pos = 7'd3;
        i_inj_dbl = 1'b0;
        tick();
        i_inj_req = 1'b0;
        chk("same_cycle_word", {o_valid, o_parity, o_pattern}, {1'b1, ref_enc(a, 1, 0, 0, 0)});
        chk("same_cycle_armed", 73'(o_inj_busy), 73'd1);
        tick();
        send_one(64'h0, {8'h00, 64'h1}, "same_cycle_next");

        for (int i = 0; i < 12; i++) begin
            d = {$urandom, $urandom};
            pos = int'($urandom_range(0, 80));
            dbl = 1'($urandom_range(0, 1));
            en = 1'($urandom_range(0, 3) != 0);
            i_en = en;
            arm(pos, dbl);
            chk("rinj_armed", 73'(o_inj_busy), 73'd1);
            send_one(d, ref_enc(d, en, 1, pos, dbl), $sformatf("rinj%0d_p%0d_d%0d_e%0d", i, pos, dbl, en));
            chk("rinj_clear", 73'(o_inj_busy), 73'd0);
        end
        i_en = 1'b1;

        i_ready = 1'b0;
        i_valid = 1'b1;
        i_pattern = 64'hA5;
        tick();
        i_pattern = 64'h5A;
        i_inj_req = 1'b1;
        i_inj_pos = 7'd3;
        i_inj_dbl = 1'b0;
        tick();
        i_valid = 1'b0;
        i_inj_req = 1'b0;
        chk("mid_pre", {o_valid, o_ready, o_inj_busy}, 73'b101);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 73'(o_valid), 73'd0);
        chk("mid_rst_busy", 73'(o_inj_busy), 73'd0);
        chk("mid_rst_out", {o_parity, o_pattern, o_ready}, 73'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        send_one(64'h0, {8'h00, 64'h0}, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hamming_enc_pipe.md
HAMMING_ENC_PIPE -- requirements
Module: hamming_enc_pipe

Interface
REQ-001 Parameter DATA_W, default 64, data bits per word; the width of pattern_t.
REQ-002 Parameter PAR_W, default 8, check bits: 7 Hamming bits plus 1 overall parity bit; the width of parity_t.
REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 i_en  in  1  encode enable; 0 forces o_parity to all-zero for words passing stage 2.
REQ-006 i_pattern  in  DATA_W  data word to encode.
REQ-007 i_valid  in  1  i_pattern is valid.
REQ-008 o_ready  out  1  block accepts i_pattern this cycle.
REQ-009 i_inj_req  in  1  one-cycle pulse that arms error injection.
REQ-010 i_inj_pos  in  7  code position to corrupt (1..72).
REQ-011 i_inj_dbl  in  1  when set, also corrupt position i_inj_pos+1 (72 wraps to 1).
REQ-012 o_inj_busy  out  1  injection is armed and not yet applied.
REQ-013 o_pattern  out  DATA_W  data word, possibly corrupted by injection.
REQ-014 o_parity  out  PAR_W  check bits {overall, h[6:0]}.
REQ-015 o_valid  out  1  o_pattern/o_parity are valid.
REQ-016 i_ready  in  1  downstream accepts the output this cycle.

Function
REQ-017 Code layout: positions 1..71; h[k] sits at position 2^k; data bits fill the non-power-of-two positions in ascending order, with i_pattern[0] at position 3 and i_pattern[63] at position 71.
REQ-018 h[k] is the XOR of all data bits whose position has bit k set; o_parity[7] is the XOR of all data bits and h[6:0]; position 72 denotes o_parity[7].
REQ-019 The pipeline has two register stages, S1 and S2. S1 registers data and h[6:0]. S2 registers data, the full parity and injection. Latency from acceptance to o_valid is exactly 2 cycles when i_ready is held high.
REQ-020 Input handshake: a word is accepted when i_valid && o_ready; o_ready = !S1.v || !S2.v || i_ready, combinational.
REQ-021 Output handshake: the output word is consumed when o_valid && i_ready; o_valid = S2.v.
REQ-022 While o_valid=1 and i_ready=0, o_pattern/o_parity hold stable and S2 does not change.
REQ-023 S1 advances into S2 when S2 is empty or S2 is consumed in the same cycle; S1 loads a new word only when it is empty or advancing.
REQ-024 Full throughput: one word per cycle when i_valid=i_ready=1; no bubbles, drops or duplicates under any i_valid/i_ready pattern.
REQ-025 Injection arming: i_inj_req=1 with o_inj_busy=0 captures i_inj_pos and i_inj_dbl and sets o_inj_busy.
REQ-026 i_inj_req while o_inj_busy=1 is ignored.
REQ-027 Injection application: the armed injection applies to the next word moving S1->S2, flipping the data or check bit at the captured position(s), after parity is computed.
REQ-028 o_inj_busy clears on the same edge that the armed injection is applied.
REQ-029 Injection to a position of 0 or greater than 72 is discarded on application: o_inj_busy clears and no bit flips.
REQ-030 Arming and application in the same cycle: the new request does not affect the word moving that cycle.
REQ-031 i_en is sampled when a word moves S1->S2; i_en=0 gives o_parity=0 for that word, with injection still applied afterwards.

Reset
REQ-032 While i_rst_n=0: S1.v=S2.v=0, o_valid=0, o_inj_busy=0, o_pattern=0, o_parity=0, and o_ready=1 once S1/S2 are empty.
REQ-033 Reset asserted mid-operation discards all in-flight words and any armed injection.
REQ-034 First acceptance is possible on the first rising edge after i_rst_n deasserts.

Verification
REQ-035 Reset, then i_pattern=0x0 with i_valid=1 and i_ready=1 -> 2 cycles later o_valid=1, o_pattern=0, o_parity=0x00.
REQ-036 i_pattern=0x1 -> o_parity=0x83; i_pattern=0x2 -> o_parity=0x85; back-to-back words emerge in order on consecutive cycles.
REQ-037 Stream 8 words with i_ready toggling 1,0,0,1,... -> exactly 8 outputs, in order, with outputs held stable while stalled.
REQ-038 Arm injection with pos=3, dbl=0, then send 0x0 -> o_pattern=0x1, o_parity=0x00, and o_inj_busy drops on the apply edge.
REQ-039 Arm injection with pos=72, dbl=1, then send 0x0 -> o_parity=0x81, o_pattern=0; a second request while busy has no effect.
REQ-040 Assert i_rst_n=0 with 2 words in flight and injection armed -> o_valid=0 and o_inj_busy=0 immediately; after release, the next word is encoded without injection.
